// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
// Multicycle integer divider for DIV/DIVU. A restoring shift-subtract loop
// produces one quotient bit per clock. A final cycle applies sign correction
// and writes the quotient and remainder, which are then held for the
// HI/LO write-back mux. Divide-by-zero skips the loop and is flagged.
//
// Ports
//   i_clk       clock, all state changes on the rising edge
//   i_reset     synchronous active-high reset, overrides every other input
//   i_start     begin a division, accepted only while idle
//   i_signed    1 = DIV (two's complement), 0 = DIVU, sampled with i_start
//   i_dividend  rs operand, sampled with i_start
//   i_divisor   rt operand, sampled with i_start
//   o_lo        quotient (registered)
//   o_hi        remainder (registered)
//   o_busy      high while the loop or the sign-fix cycle is running
//   o_done      one-cycle pulse; o_lo/o_hi are valid from this cycle
//   o_divZero   one-cycle pulse together with o_done when the divisor was 0
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_divZero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_nextState;

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divMag;
    logic             r_negQuo;
    logic             r_negRem;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_divZero;

    logic             w_divisorZero;
    logic             w_dividendNeg;
    logic             w_divisorNeg;
    logic [WIDTH:0]   w_shifted;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic             w_lastBit;

    // Operand signs only matter for DIV; negating the most negative value
    // yields the same bit pattern, which read as unsigned is its magnitude.
    assign w_divisorZero = (i_divisor == '0);
    assign w_dividendNeg = i_signed & i_dividend[WIDTH-1];
    assign w_divisorNeg  = i_signed & i_divisor[WIDTH-1];

    // The partial remainder shifted left with the next dividend bit can need
    // WIDTH+1 bits, so the compare is done one bit wider than the operands.
    // When the compare succeeds the difference is below the divisor and fits
    // in WIDTH bits.
    assign w_shifted = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_shifted >= {1'b0, r_divMag});
    assign w_diff    = w_shifted[WIDTH-1:0] - r_divMag;
    assign w_lastBit = (r_count == CW'(WIDTH - 1));

    // Next-state decode: start leaves idle (straight to DONE on a zero
    // divisor), the loop runs WIDTH cycles, then one fix cycle, then a
    // single done cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nextState = w_divisorZero ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_lastBit) begin
                    w_nextState = FIX;
                end
            end
            FIX:     w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // State and datapath registers. The quotient register also holds the
    // dividend magnitude; its MSB feeds the remainder each cycle while the
    // new quotient bit enters at the LSB.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divMag  <= '0;
            r_negQuo  <= 1'b0;
            r_negRem  <= 1'b0;
            r_count   <= '0;
            r_lo      <= '0;
            r_hi      <= '0;
            r_divZero <= 1'b0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        if (w_divisorZero) begin
                            r_divZero <= 1'b1;
                        end else begin
                            r_divZero <= 1'b0;
                            r_quo     <= w_dividendNeg ? -i_dividend : i_dividend;
                            r_divMag  <= w_divisorNeg ? -i_divisor : i_divisor;
                            r_negQuo  <= w_dividendNeg ^ w_divisorNeg;
                            r_negRem  <= w_dividendNeg;
                            r_rem     <= '0;
                            r_count   <= '0;
                        end
                    end
                end
                CALC: begin
                    if (w_ge) begin
                        r_rem <= w_diff;
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shifted[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                    r_count <= r_count + 1'b1;
                end
                FIX: begin
                    r_lo <= r_negQuo ? -r_quo : r_quo;
                    r_hi <= r_negRem ? -r_rem : r_rem;
                end
                DONE: begin
                    r_divZero <= 1'b0;
                end
                default: begin
                    r_divZero <= 1'b0;
                end
            endcase
        end
    end

    assign o_lo      = r_lo;
    assign o_hi      = r_hi;
    assign o_busy    = (r_state == CALC) || (r_state == FIX);
    assign o_done    = (r_state == DONE);
    assign o_divZero = (r_state == DONE) && r_divZero;

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
// Directed testbench for div_unit: reset state, unsigned and signed
// division, divide-by-zero, signed overflow, reset mid-operation, ignored
// start while busy, and a batch of random operands checked against the
// division identity.
// ---------------------------------------------------------------------------
module tb_div_unit;

    logic        i_clk;
    logic        i_reset;
    logic        i_start;
    logic        i_signed;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic [31:0] o_lo;
    logic [31:0] o_hi;
    logic        o_busy;
    logic        o_done;
    logic        o_divZero;

    int checks;
    int errors;

    div_unit #(.WIDTH(32)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_signed   (i_signed),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .o_lo       (o_lo),
        .o_hi       (o_hi),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_divZero  (o_divZero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Drive a one-cycle start pulse; returns just after the sampling edge
    // (edge 0), at the following falling edge.
    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge i_clk);
        i_start    = 1'b1;
        i_signed   = sgn;
        i_dividend = a;
        i_divisor  = b;
        @(negedge i_clk);
        i_start    = 1'b0;
        i_dividend = 32'hDEAD_BEEF;
        i_divisor  = 32'h0000_0003;
    endtask

    // Wait for o_done, counting edges after edge 0 and busy samples.
    task automatic waitDone(output int latency, output int busyCycles);
        latency    = 0;
        busyCycles = 0;
        while (!o_done && latency < 100) begin
            if (o_busy) busyCycles++;
            @(negedge i_clk);
            latency++;
        end
    endtask

    task automatic test_reset;
        i_reset    = 1'b1;
        i_start    = 1'b0;
        i_signed   = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_lo !== 32'd0 || o_hi !== 32'd0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_divZero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: lo=%h hi=%h busy=%b done=%b dz=%b, expected all zero",
                     o_lo, o_hi, o_busy, o_done, o_divZero);
        end
        i_reset = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_divu_basic;
        int lat;
        int busy;
        applyStimulus(1'b0, 32'd100, 32'd7);
        waitDone(lat, busy);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("[TB] FAIL divu_latency: got %0d edges, expected 33", lat);
        end
        checks++;
        if (busy !== 33) begin
            errors++;
            $display("[TB] FAIL divu_busy_cycles: got %0d, expected 33", busy);
        end
        checks++;
        if (o_lo !== 32'd14 || o_hi !== 32'd2 || o_divZero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL divu_100_7: lo=%0d hi=%0d dz=%b, expected lo=14 hi=2 dz=0", o_lo, o_hi, o_divZero);
        end
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_one_cycle: done=%b busy=%b, expected 0 0", o_done, o_busy);
        end
    endtask

    task automatic test_signed;
        logic        sgnT [3];
        logic [31:0] aT   [3];
        logic [31:0] bT   [3];
        logic [31:0] qT   [3];
        logic [31:0] rT   [3];
        int lat;
        int busy;
        sgnT[0] = 1'b1; aT[0] = 32'hFFFF_FFF9; bT[0] = 32'd2;        qT[0] = 32'hFFFF_FFFD; rT[0] = 32'hFFFF_FFFF;
        sgnT[1] = 1'b1; aT[1] = 32'd7;         bT[1] = 32'hFFFF_FFFE; qT[1] = 32'hFFFF_FFFD; rT[1] = 32'd1;
        sgnT[2] = 1'b0; aT[2] = 32'hFFFF_FFFF; bT[2] = 32'd1;         qT[2] = 32'hFFFF_FFFF; rT[2] = 32'd0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(sgnT[i], aT[i], bT[i]);
            waitDone(lat, busy);
            checks++;
            if (o_done !== 1'b1 || o_lo !== qT[i] || o_hi !== rT[i]) begin
                errors++;
                $display("[TB] FAIL signed_vec%0d: done=%b lo=%h hi=%h, expected done=1 lo=%h hi=%h",
                         i, o_done, o_lo, o_hi, qT[i], rT[i]);
            end
            @(negedge i_clk);
        end
    endtask

    task automatic test_div_zero;
        int lat;
        int busy;
        int busySeen;
        applyStimulus(1'b0, 32'd59, 32'd10);
        waitDone(lat, busy);
        checks++;
        if (o_lo !== 32'd5 || o_hi !== 32'd9) begin
            errors++;
            $display("[TB] FAIL divz_setup: lo=%0d hi=%0d, expected 5 9", o_lo, o_hi);
        end
        @(negedge i_clk);
        applyStimulus(1'b1, 32'd42, 32'd0);
        checks++;
        if (o_done !== 1'b1 || o_divZero !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL divz_pulse: done=%b dz=%b busy=%b, expected 1 1 0", o_done, o_divZero, o_busy);
        end
        checks++;
        if (o_lo !== 32'd5 || o_hi !== 32'd9) begin
            errors++;
            $display("[TB] FAIL divz_hold: lo=%0d hi=%0d, expected 5 9", o_lo, o_hi);
        end
        busySeen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            if (o_busy || o_done || o_divZero) busySeen++;
        end
        checks++;
        if (busySeen !== 0) begin
            errors++;
            $display("[TB] FAIL divz_after: %0d cycles with busy/done/dz high, expected 0", busySeen);
        end
    endtask

    task automatic test_overflow;
        int lat;
        int busy;
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone(lat, busy);
        checks++;
        if (o_done !== 1'b1 || o_lo !== 32'h8000_0000 || o_hi !== 32'd0 || o_divZero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow: lo=%h hi=%h dz=%b, expected lo=80000000 hi=0 dz=0", o_lo, o_hi, o_divZero);
        end
        @(negedge i_clk);
    endtask

    task automatic test_reset_mid;
        int lat;
        int busy;
        int doneSeen;
        applyStimulus(1'b0, 32'd1000, 32'd10);
        repeat (9) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        checks++;
        if (o_lo !== 32'd0 || o_hi !== 32'd0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_divZero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid: lo=%h hi=%h busy=%b done=%b dz=%b, expected all zero",
                     o_lo, o_hi, o_busy, o_done, o_divZero);
        end
        doneSeen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge i_clk);
            if (o_done || o_busy) doneSeen++;
        end
        checks++;
        if (doneSeen !== 0) begin
            errors++;
            $display("[TB] FAIL reset_abort: %0d cycles with busy/done, expected 0", doneSeen);
        end
        applyStimulus(1'b0, 32'd9, 32'd4);
        waitDone(lat, busy);
        checks++;
        if (lat !== 33 || o_lo !== 32'd2 || o_hi !== 32'd1) begin
            errors++;
            $display("[TB] FAIL after_reset: lat=%0d lo=%0d hi=%0d, expected 33 2 1", lat, o_lo, o_hi);
        end
        @(negedge i_clk);
    endtask

    task automatic test_back_to_back;
        int doneCount;
        int doneAt;
        logic [31:0] loAt;
        logic [31:0] hiAt;
        applyStimulus(1'b0, 32'd50, 32'd5);
        doneCount = 0;
        doneAt    = -1;
        loAt      = '0;
        hiAt      = '0;
        for (int e = 0; e < 45; e++) begin
            if (e == 4) begin
                i_start    = 1'b1;
                i_dividend = 32'd7;
                i_divisor  = 32'd7;
            end else begin
                i_start = 1'b0;
            end
            if (o_done) begin
                doneCount++;
                doneAt = e;
                loAt   = o_lo;
                hiAt   = o_hi;
            end
            @(negedge i_clk);
        end
        checks++;
        if (doneCount !== 1 || doneAt !== 33) begin
            errors++;
            $display("[TB] FAIL ignore_start: done pulses=%0d at=%0d, expected 1 at 33", doneCount, doneAt);
        end
        checks++;
        if (loAt !== 32'd10 || hiAt !== 32'd0) begin
            errors++;
            $display("[TB] FAIL ignore_start_result: lo=%0d hi=%0d, expected 10 0", loAt, hiAt);
        end
    endtask

    task automatic test_random;
        int lat;
        int busy;
        int bad;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] recon;
        logic [31:0] magHi;
        logic [31:0] magB;
        bad = 0;
        for (int n = 0; n < 200; n++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom;
            if (n % 4 == 1) b = b >> $urandom_range(8, 30);
            if (b == 0) b = 32'd3;
            applyStimulus(sgn, a, b);
            waitDone(lat, busy);
            recon = o_lo * b + o_hi;
            if (sgn) begin
                magHi = o_hi[31] ? -o_hi : o_hi;
                magB  = b[31] ? -b : b;
            end else begin
                magHi = o_hi;
                magB  = b;
            end
            if (lat != 33 || recon !== a || magHi >= magB ||
                (sgn && o_hi != 0 && o_hi[31] !== a[31])) begin
                bad++;
                if (bad <= 5)
                    $display("[TB] FAIL random_invariant: s=%b a=%h b=%h lo=%h hi=%h lat=%0d",
                             sgn, a, b, o_lo, o_hi, lat);
            end
            @(negedge i_clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL random_total: %0d bad results, expected 0", bad);
        end
    endtask

    task automatic checkOutput;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        test_random();
        checkOutput();
        $finish;
    end

endmodule
